// File: rtl/iis_tx_port.sv
// I2S / left-justified / right-justified master transmitter.
// Generates sck/lrclk from pclk and serialises one stereo sample pair per 64-bit frame.
module iis_tx_port #(
  parameter int unsigned SCK_DIV = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  regmap_iis_bitsnum,
  input  logic [1:0]  regmap_iis_port_sel,
  input  logic        din_valid,
  input  logic [23:0] din_left,
  input  logic [23:0] din_right,
  output logic        din_ready,
  output logic        underflow,
  output logic        sck,
  output logic        lrclk,
  output logic        sdout
);

  localparam int unsigned      DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCK_DIV - 1);

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_RJ  = 2'd2
  } fmt_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sck;
  logic [5:0]       r_bit_cnt;
  logic             r_lrclk;
  logic             r_sdout;
  logic             r_din_ready;
  logic             r_underflow;
  fmt_t             r_fmt;
  logic [4:0]       r_len;
  logic [47:0]      r_sample;

  logic             w_tc;
  logic             w_fall;
  logic             w_load;
  logic [5:0]       w_bit_nxt;
  logic [5:0]       w_bit_inc;
  fmt_t             w_fmt_nxt;
  logic [4:0]       w_len_nxt;
  logic [47:0]      w_sample_nxt;
  logic [23:0]      w_word;
  logic [5:0]       w_off;
  logic [5:0]       w_k;
  logic [5:0]       w_j;
  logic             w_sd;
  logic             w_lr;

  // Output bit is computed from the post-fall bit_cnt and the config/sample that this
  // same fall event latches, so slot position 0 of a new frame already carries new data.
  always_comb begin
    w_tc         = (r_div_cnt == DIV_TC);
    w_fall       = w_tc & r_sck;
    w_load       = w_fall & (r_bit_cnt == 6'd63);
    w_bit_nxt    = r_bit_cnt + 6'd1;
    w_bit_inc    = w_bit_nxt + 6'd1;
    w_fmt_nxt    = r_fmt;
    w_len_nxt    = r_len;
    w_sample_nxt = r_sample;
    if (w_load) begin
      case (regmap_iis_port_sel)
        2'b01:   w_fmt_nxt = FMT_LJ;
        2'b10:   w_fmt_nxt = FMT_RJ;
        default: w_fmt_nxt = FMT_I2S;
      endcase
      case (regmap_iis_bitsnum)
        2'b00:   w_len_nxt = 5'd16;
        2'b01:   w_len_nxt = 5'd20;
        default: w_len_nxt = 5'd24;
      endcase
      w_sample_nxt = din_valid ? {din_left, din_right} : '0;
    end

    w_word = w_bit_nxt[5] ? w_sample_nxt[23:0] : w_sample_nxt[47:24];
    case (w_fmt_nxt)
      FMT_LJ:  w_off = 6'd0;
      FMT_RJ:  w_off = 6'd32 - {1'b0, w_len_nxt};
      default: w_off = 6'd1;
    endcase
    w_k  = {1'b0, w_bit_nxt[4:0]};
    w_j  = w_k - w_off;
    w_sd = 1'b0;
    if ((w_k >= w_off) && (w_j < {1'b0, w_len_nxt})) begin
      w_sd = w_word[5'd23 - w_j[4:0]];
    end
    w_lr = (w_fmt_nxt == FMT_I2S) ? w_bit_inc[5] : w_bit_nxt[5];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_sck       <= 1'b0;
      r_bit_cnt   <= 6'd63;
      r_lrclk     <= 1'b0;
      r_sdout     <= 1'b0;
      r_din_ready <= 1'b0;
      r_underflow <= 1'b0;
      r_fmt       <= FMT_I2S;
      r_len       <= '0;
      r_sample    <= '0;
    end else if (!enable) begin
      r_div_cnt   <= '0;
      r_sck       <= 1'b0;
      r_bit_cnt   <= 6'd63;
      r_lrclk     <= 1'b0;
      r_sdout     <= 1'b0;
      r_din_ready <= 1'b0;
      r_underflow <= 1'b0;
      r_fmt       <= FMT_I2S;
      r_len       <= '0;
      r_sample    <= '0;
    end else begin
      r_din_ready <= w_load;
      r_underflow <= w_load & ~din_valid;
      if (w_tc) begin
        r_div_cnt <= '0;
        r_sck     <= ~r_sck;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_sdout   <= w_sd;
        r_lrclk   <= w_lr;
      end
      if (w_load) begin
        r_fmt    <= w_fmt_nxt;
        r_len    <= w_len_nxt;
        r_sample <= w_sample_nxt;
      end
    end
  end

  assign sck       = r_sck;
  assign lrclk     = r_lrclk;
  assign sdout     = r_sdout;
  assign din_ready = r_din_ready;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_iis_tx_port.sv
// Self-checking bench for iis_tx_port: cycle-level reference model derived from elapsed
// enabled cycles, plus directed frame captures and a randomized soak.
module tb_iis_tx_port;

  localparam int SCK_DIV = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  bitsnum = 2'b10;
  logic [1:0]  port_sel = 2'b00;
  logic        din_valid = 1'b0;
  logic [23:0] din_left = '0;
  logic [23:0] din_right = '0;
  logic        din_ready, underflow, sck, lrclk, sdout;

  iis_tx_port #(.SCK_DIV(SCK_DIV)) dut (
    .pclk               (pclk),
    .rst_n              (rst_n),
    .enable             (enable),
    .regmap_iis_bitsnum (bitsnum),
    .regmap_iis_port_sel(port_sel),
    .din_valid          (din_valid),
    .din_left           (din_left),
    .din_right          (din_right),
    .din_ready          (din_ready),
    .underflow          (underflow),
    .sck                (sck),
    .lrclk              (lrclk),
    .sdout              (sdout)
  );

  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: everything follows from t, the count of enabled edges.
  int   t = 0;
  int   m_bit = 63;
  logic m_sck = 0, m_lr = 0, m_sd = 0, m_rdy = 0, m_uf = 0, m_fall = 0;
  logic fsd[64];
  logic flr[64];
  logic cap[64];
  logic capl[64];
  int   cyc = 0, last_rdy = -1, rdy_period = 0, uf_cnt = 0;

  task automatic build_frame();
    int n, off, ch, k, j;
    logic i2s;
    logic [23:0] w;
    n   = (bitsnum == 2'b00) ? 16 : (bitsnum == 2'b01) ? 20 : 24;
    i2s = !(port_sel == 2'b01 || port_sel == 2'b10);
    off = (port_sel == 2'b01) ? 0 : (port_sel == 2'b10) ? 32 - n : 1;
    for (int b = 0; b < 64; b++) begin
      ch = b / 32;
      k  = b % 32;
      w  = din_valid ? (ch == 1 ? din_right : din_left) : 24'h0;
      j  = k - off;
      fsd[b] = (j >= 0 && j < n) ? w[23 - j] : 1'b0;
      flr[b] = i2s ? (((b + 1) % 64) / 32 == 1) : (ch == 1);
    end
  endtask

  task automatic model_step();
    int g0, g1;
    if (!rst_n || !enable) begin
      t = 0; m_sck = 0; m_lr = 0; m_sd = 0; m_rdy = 0; m_uf = 0; m_fall = 0; m_bit = 63;
    end else begin
      g0 = t / SCK_DIV;
      t++;
      g1 = t / SCK_DIV;
      m_sck  = (g1 % 2 == 1);
      m_fall = (g1 != g0) && (g1 % 2 == 0);
      m_rdy  = 0;
      m_uf   = 0;
      if (m_fall) begin
        m_bit = (63 + g1 / 2) % 64;
        if (m_bit == 0) begin
          m_rdy = 1;
          m_uf  = !din_valid;
          build_frame();
        end
        m_sd = fsd[m_bit];
        m_lr = flr[m_bit];
      end
    end
  endtask

  // Inputs are only changed after this returns, so the model sees what the DUT sampled.
  task automatic tick();
    @(negedge pclk);
    cyc++;
    model_step();
    check("sck", sck, m_sck);
    check("lrclk", lrclk, m_lr);
    check("sdout", sdout, m_sd);
    check("din_ready", din_ready, m_rdy);
    check("underflow", underflow, m_uf);
    if (m_fall) begin
      cap[m_bit]  = sdout;
      capl[m_bit] = lrclk;
    end
    if (din_ready) begin
      if (last_rdy >= 0) rdy_period = cyc - last_rdy;
      last_rdy = cyc;
    end
    if (underflow) uf_cnt++;
  endtask

  task automatic wait_bit(input int b);
    logic found;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (m_fall && m_bit == b) found = 1;
    end
    check("wait_bit", found, 1'b1);
  endtask

  task automatic run_frame();
    wait_bit(0);
    wait_bit(63);
  endtask

  function automatic logic [31:0] get_word(input int start, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], cap[start + i]};
    return r;
  endfunction

  initial begin
    int cnt, ones;
    logic got;

    // 1: reset, long disabled idle, then first din_ready latency
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b1;
    bitsnum = 2'b10; port_sel = 2'b00;
    din_left = 24'hA5A5A5; din_right = 24'h5A5A5A; din_valid = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    enable = 1'b1;
    cnt = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (din_ready) begin got = 1; cnt = i; end
    end
    check("first_ready_latency", cnt, 4);

    // 2: I2S 24-bit
    run_frame();
    check("i2s_left", get_word(1, 24), 32'hA5A5A5);
    check("i2s_right", get_word(33, 24), 32'h5A5A5A);
    check("i2s_k0_zero", {cap[0], cap[32]}, 2'b00);
    check("i2s_left_tail", get_word(25, 7), 0);
    check("i2s_lr_lead", {capl[62], capl[63], capl[30], capl[31]}, 4'b1001);
    check("ready_period", rdy_period, 256);

    // 3: LJ 16-bit
    port_sel = 2'b01; bitsnum = 2'b00; din_left = 24'h1234FF;
    run_frame();
    check("lj16_left", get_word(0, 16), 32'h1234);
    check("lj16_tail", get_word(16, 16), 0);

    // 4: RJ 20-bit
    port_sel = 2'b10; bitsnum = 2'b01; din_right = 24'hFFFFF0;
    run_frame();
    check("rj20_pad", get_word(32, 12), 0);
    check("rj20_data", get_word(44, 20), 32'hFFFFF);
    ones = 0;
    for (int b = 32; b < 64; b++) ones += int'(capl[b]);
    check("rj20_lr_right", ones, 32);

    // 5: underflow frame, then recovery
    din_valid = 1'b0; uf_cnt = 0;
    run_frame();
    check("uf_count", uf_cnt, 1);
    check("uf_mute_l", get_word(0, 32), 0);
    check("uf_mute_r", get_word(32, 32), 0);
    din_valid = 1'b1;
    run_frame();
    check("uf_resume", get_word(44, 20), 32'hFFFFF);

    // 6: mid-frame format change, then abort and restart
    port_sel = 2'b00; bitsnum = 2'b10; din_left = 24'hA5A5A5;
    wait_bit(0);
    wait_bit(40);
    port_sel = 2'b01;
    wait_bit(63);
    check("cfg_hold_i2s", get_word(1, 24), 32'hA5A5A5);
    run_frame();
    check("cfg_next_lj", get_word(0, 24), 32'hA5A5A5);
    wait_bit(0);
    wait_bit(20);
    enable = 1'b0;
    tick();
    check("abort_outs", {sck, lrclk, sdout, din_ready, underflow}, 5'b0);
    din_left = 24'h0F0F0F;
    for (int i = 0; i < 7; i++) tick();
    enable = 1'b1;
    run_frame();
    check("restart_fresh", get_word(0, 24), 32'h0F0F0F);

    // randomized soak against the model
    for (int i = 0; i < 9000; i++) begin
      tick();
      if (m_rdy) begin
        din_left  = 24'($urandom);
        din_right = 24'($urandom);
        din_valid = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 199) == 0) begin
        bitsnum  = 2'($urandom);
        port_sel = 2'($urandom);
      end
      if ($urandom_range(0, 2999) == 0) begin
        enable = 1'b0;
        tick();
        enable = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
